mem_arbiter: RTL and testbench

Two-port arbiter that lets the `mips` core's instruction-fetch port and data port share one single-ported unified memory. Each port uses a request/acknowledge handshake; the memory side uses a request/ready handshake with variable latency. Data accesses have priority, and a bounded streak counter prevents instruction-fetch starvation. The block sits between the core's memory ports and the memory model or controller.

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and the port-priority helper for mem_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    // Data wins by default; instruction wins a contested cycle once the data
    // streak has saturated, and wins trivially when it is the only requester.
    function automatic arb_port_t pick_port(
        input logic eligible_i,
        input logic eligible_d,
        input logic streak_full
    );
        arb_port_t w_port;
        if (eligible_i && eligible_d && streak_full) begin
            w_port = PORT_I;
        end else if (eligible_d) begin
            w_port = PORT_D;
        end else begin
            w_port = PORT_I;
        end
        return w_port;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one single-ported memory between the instruction-fetch
//             and data ports of the core. Data has priority; a saturating
//             streak counter bounds how long instruction fetch can starve.
//             All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    // instruction port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int                    c_STREAK_W   = $clog2(D_STREAK_MAX + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(D_STREAK_MAX);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    arb_port_t             w_pick;
    logic                  w_elig_i;
    logic                  w_elig_d;
    logic                  w_grant;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_done_i;
    logic                  w_done_d;
    logic                  w_streak_full;

    logic [c_STREAK_W-1:0] r_streak;
    logic                  r_i_ack;
    logic                  r_d_ack;
    logic [DATA_W-1:0]     r_i_rdata;
    logic [DATA_W-1:0]     r_d_rdata;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;

    assign w_streak_full = (r_streak == c_STREAK_MAX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: arbitrate in IDLE (a port in its ack cycle is not eligible),
    // return to IDLE when the memory completes.
    always_comb begin
        w_elig_i     = i_req && !r_i_ack;
        w_elig_d     = d_req && !r_d_ack;
        w_grant      = 1'b0;
        w_pick       = PORT_I;
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_elig_i || w_elig_d) begin
                    w_grant      = 1'b1;
                    w_pick       = pick_port(w_elig_i, w_elig_d, w_streak_full);
                    w_next_state = (w_pick == PORT_D) ? ARB_SERVE_D : ARB_SERVE_I;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (mem_ready) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Output decode: which port is granted this cycle, which access completes.
    always_comb begin
        w_grant_i = w_grant && (w_pick == PORT_I);
        w_grant_d = w_grant && (w_pick == PORT_D);
        w_done_i  = (r_state == ARB_SERVE_I) && mem_ready;
        w_done_d  = (r_state == ARB_SERVE_D) && mem_ready;
    end

    // Memory-side request registers and port ack/read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_i_ack <= w_done_i;
            r_d_ack <= w_done_d;
            if (w_done_i) begin
                r_i_rdata <= mem_rdata;
            end
            // Write completions leave the last read value in place.
            if (w_done_d && !r_mem_we) begin
                r_d_rdata <= mem_rdata;
            end
            if (w_done_i || w_done_d) begin
                r_mem_req <= 1'b0;
            end
            if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_addr;
                r_mem_wdata <= '0;
            end
        end
    end

    // Streak of data grants taken while instruction fetch was waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (w_grant_i) begin
            r_streak <= '0;
        end else if (w_grant_d) begin
            if (!i_req) begin
                r_streak <= '0;
            end else if (!w_streak_full) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

    assign i_ack     = r_i_ack;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: directed steps, a
//             wait-programmable memory model and an ack scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    // memory model: ready after m_wait low cycles of an active request
    int          m_wait  = 0;
    int          m_cnt   = 0;
    logic [31:0] m_rdata = '0;
    assign mem_ready = (m_cnt >= m_wait);
    assign mem_rdata = m_rdata;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req && !mem_ready) m_cnt <= m_cnt + 1;
        else                       m_cnt <= 0;
    end

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_STREAK_MAX(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_d, input logic [31:0] rdata);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Ack monitor: every ack must match the oldest expected completion.
    logic prev_i = 1'b0;
    logic prev_d = 1'b0;
    always @(negedge clk) begin
        if (!reset && (i_ack || d_ack)) begin
            check("dual_ack", {63'd0, i_ack && d_ack}, 64'd0);
            if (i_ack) check("i_ack_b2b", {63'd0, prev_i}, 64'd0);
            if (d_ack) check("d_ack_b2b", {63'd0, prev_d}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_port", {63'd0, d_ack}, {63'd0, e.is_d});
                if (d_ack) check("sb_d_rdata", {32'd0, d_rdata}, {32'd0, e.rdata});
                else       check("sb_i_rdata", {32'd0, i_rdata}, {32'd0, e.rdata});
            end
        end
        prev_i <= i_ack;
        prev_d <= d_ack;
    end

    initial begin
        int acks;
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h40;
        d_wdata = '0;
        m_wait  = 0;
        m_rdata = 32'hA5A5_0001;

        // reset held two cycles with a pending data read
        step();
        check("rst_outs_c1", {63'd0, |{i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata}}, 64'd0);
        step();
        check("rst_outs_c2", {63'd0, |{i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata}}, 64'd0);
        reset = 1'b0;
        push(1'b1, 32'hA5A5_0001);
        check("rst_no_req_yet", {63'd0, mem_req}, 64'd0);
        step();
        check("rst_first_req", {63'd0, mem_req}, 64'd1);
        check("rst_first_addr", {32'd0, mem_addr}, 64'h40);
        step();
        check("rst_d_ack", {63'd0, d_ack}, 64'd1);
        d_req = 1'b0;
        step();

        // instruction read, zero wait
        m_rdata = 32'hDEAD_BEEF;
        i_addr  = 32'h100;
        i_req   = 1'b1;
        push(1'b0, 32'hDEAD_BEEF);
        step();
        check("ird_req", {63'd0, mem_req}, 64'd1);
        check("ird_addr", {32'd0, mem_addr}, 64'h100);
        check("ird_we0", {63'd0, mem_we}, 64'd0);
        check("ird_no_ack_early", {63'd0, i_ack}, 64'd0);
        step();
        check("ird_ack", {63'd0, i_ack}, 64'd1);
        check("ird_rdata", {32'd0, i_rdata}, 64'hDEAD_BEEF);
        check("ird_we0_ack", {63'd0, mem_we}, 64'd0);
        check("ird_req_drop", {63'd0, mem_req}, 64'd0);
        i_req = 1'b0;
        step();
        check("ird_ack_pulse", {63'd0, i_ack}, 64'd0);

        // data write with three wait states; d_rdata keeps the earlier read
        m_wait  = 3;
        d_we    = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'h1234_5678;
        d_req   = 1'b1;
        push(1'b1, 32'hA5A5_0001);
        for (int k = 0; k < 4; k++) begin
            step();
            check("wr_req", {63'd0, mem_req}, 64'd1);
            check("wr_we", {63'd0, mem_we}, 64'd1);
            check("wr_addr", {32'd0, mem_addr}, 64'h2000);
            check("wr_wdata", {32'd0, mem_wdata}, 64'h1234_5678);
            check("wr_no_ack", {63'd0, d_ack}, 64'd0);
        end
        step();
        check("wr_ack", {63'd0, d_ack}, 64'd1);
        check("wr_i_rdata_hold", {32'd0, i_rdata}, 64'hDEAD_BEEF);
        d_req = 1'b0;
        step();

        // streak limit: the instruction request is masked in data-ack cycles,
        // so every data grant is a contested one and the streak climbs to 4
        m_wait  = 0;
        m_rdata = 32'h5555_AAAA;
        d_we    = 1'b0;
        d_addr  = 32'h400;
        i_addr  = 32'h300;
        for (int k = 0; k < 10; k++) push((k % 5) != 4, 32'h5555_AAAA);
        d_req = 1'b1;
        i_req = 1'b1;
        acks  = 0;
        for (int c = 0; c < 200 && acks < 10; c++) begin
            step();
            if (i_ack || d_ack) acks++;
            if (acks < 10) i_req = !d_ack;
        end
        d_req = 1'b0;
        i_req = 1'b0;
        check("streak_acks", acks, 64'd10);
        step();
        step();

        // reset in the middle of a stalled data access
        m_wait  = 10;
        d_we    = 1'b1;
        d_addr  = 32'h500;
        d_wdata = 32'hCAFE_F00D;
        d_req   = 1'b1;
        i_addr  = 32'h600;
        i_req   = 1'b1;
        step();
        step();
        check("mid_serving", {63'd0, mem_req}, 64'd1);
        check("mid_streak_pre", {61'd0, dut.r_streak}, 64'd1);
        reset = 1'b1;
        d_req = 1'b0;
        i_req = 1'b0;
        step();
        check("mid_req_drop", {63'd0, mem_req}, 64'd0);
        check("mid_no_ack", {63'd0, d_ack}, 64'd0);
        check("mid_streak_clr", {61'd0, dut.r_streak}, 64'd0);
        reset = 1'b0;
        step();
        check("mid_idle_req", {63'd0, mem_req}, 64'd0);
        m_wait  = 0;
        m_rdata = 32'h0BAD_C0DE;
        i_req   = 1'b1;
        push(1'b0, 32'h0BAD_C0DE);
        step();
        check("post_req", {63'd0, mem_req}, 64'd1);
        check("post_addr", {32'd0, mem_addr}, 64'h600);
        step();
        check("post_ack", {63'd0, i_ack}, 64'd1);
        check("post_rdata", {32'd0, i_rdata}, 64'h0BAD_C0DE);
        i_req = 1'b0;
        step();
        step();
        check("sb_drained", sb.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
